// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared bias Q-format constants and loader state encoding
package bias_pkg;

  // Q-format shared by the bias FIFO, the loader and the conv datapath
  localparam int BIAS_DATA_WIDTH = 32;
  localparam int BIAS_FRAC_BITS  = 22;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_EMPTY = 2'd1,
    ST_LOAD       = 2'd2,
    ST_COMMIT     = 2'd3
  } bias_ld_state_t;

endpackage

// File: rtl/bias_fmt_convert.sv
// rtl/bias_fmt_convert.sv - sign-extend and left-shift a stream word into Q-format
module bias_fmt_convert #(
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_SHIFT = 8
) (
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  // The shifted value must fit, otherwise the conversion would silently wrap
  if (IN_WIDTH + FRAC_SHIFT > DATA_WIDTH) begin : g_bad_width
    $error("bias_fmt_convert: IN_WIDTH+FRAC_SHIFT exceeds DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] ext;

  // Sign-extend to the full word, then move the binary point into place
  always_comb begin
    ext                = {DATA_WIDTH{in_data[IN_WIDTH-1]}};
    ext[IN_WIDTH-1:0]  = in_data;
    out_data           = ext << FRAC_SHIFT;
  end

endmodule

// File: rtl/bias_preload_loader.sv
// rtl/bias_preload_loader.sv - loads one frame of biases into the bias FIFO preload port
module bias_preload_loader
  import bias_pkg::*;
#(
  parameter int DATA_WIDTH = BIAS_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int IN_WIDTH   = 16,
  parameter int FRAC_SHIFT = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_empty,
  output logic                  preload_en,
  output logic [AW-1:0]         preload_addr,
  output logic [DATA_WIDTH-1:0] preload_data,
  output logic                  preload_done
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bias_preload_loader: DEPTH must be a power of two >= 2");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  bias_ld_state_t        state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  preload_en_q, preload_en_d;
  logic [AW-1:0]         preload_addr_q, preload_addr_d;
  logic [DATA_WIDTH-1:0] preload_data_q, preload_data_d;
  logic [DATA_WIDTH-1:0] conv_data;
  logic                  s_ready_c;

  bias_fmt_convert #(
    .IN_WIDTH   (IN_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_fmt (
    .in_data  (s_data),
    .out_data (conv_data)
  );

  // Next-state and registered-output computation for the load sequence
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    err_d          = err_q;
    done_d         = 1'b0;
    preload_en_d   = 1'b0;
    preload_addr_d = preload_addr_q;
    preload_data_d = preload_data_q;
    s_ready_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        // busy_q still covers the cycle the commit pulse is visible, so a
        // start there is dropped just like any other start while busy
        if (start && !busy_q) begin
          state_d = ST_WAIT_EMPTY;
          err_d   = 1'b0;
        end
      end
      ST_WAIT_EMPTY: begin
        // Never overwrite biases the datapath has not consumed yet
        if (fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          preload_en_d   = 1'b1;
          preload_addr_d = idx_q;
          preload_data_d = conv_data;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // A missing last marker is flagged but the full frame still commits
            state_d = ST_COMMIT;
            if (!s_last) begin
              err_d = 1'b1;
            end
          end else if (s_last) begin
            // Short frame: abandon without commit so the FIFO keeps its old set
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || (state_q == ST_COMMIT);
  end

  // State and output registers, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      preload_en_q   <= 1'b0;
      preload_addr_q <= '0;
      preload_data_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      preload_en_q   <= preload_en_d;
      preload_addr_q <= preload_addr_d;
      preload_data_q <= preload_data_d;
    end
  end

  assign s_ready      = s_ready_c;
  assign busy         = busy_q;
  assign done         = done_q;
  assign preload_done = done_q;
  assign err          = err_q;
  assign preload_en   = preload_en_q;
  assign preload_addr = preload_addr_q;
  assign preload_data = preload_data_q;

endmodule

// File: tb/tb_bias_preload_loader.sv
// tb/tb_bias_preload_loader.sv - directed self-checking bench for bias_preload_loader
module tb_bias_preload_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        fifo_empty;
  logic        preload_en;
  logic [1:0]  preload_addr;
  logic [31:0] preload_data;
  logic        preload_done;

  bias_preload_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .fifo_empty   (fifo_empty),
    .preload_en   (preload_en),
    .preload_addr (preload_addr),
    .preload_data (preload_data),
    .preload_done (preload_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vals [4];
  logic [31:0] exp_data [4];

  int          wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc [$];
  int          done_cycs [$];
  int          hs_cyc [$];
  int          overlap   = 0;
  int          done_mis  = 0;
  int          busy_fall = -1;
  logic        busy_prev = 1'b0;

  // Passive monitor: records preload writes, commit pulses and busy falling edges
  always @(negedge clk) begin
    if (preload_en) begin
      wr_addr.push_back(int'(preload_addr));
      wr_data.push_back(preload_data);
      wr_cyc.push_back(cyc);
    end
    if (preload_done) done_cycs.push_back(cyc);
    if (preload_en && preload_done) overlap++;
    if (done !== preload_done) done_mis++;
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  // Offers words 0..n_words-1 with s_valid following vpat (LSB first, period plen)
  task automatic stream(input int n_words, input int last_at, input logic [7:0] vpat,
                        input int plen, input logic hold_start, output int last_hs);
    int k = 0;
    int p = 0;
    hs_cyc.delete();
    last_hs = -1;
    while (k < n_words && p < 60) begin
      s_valid = vpat[p % plen];
      s_data  = vals[k];
      s_last  = (k == last_at);
      start   = hold_start;
      if (s_valid && s_ready) begin
        hs_cyc.push_back(cyc);
        last_hs = cyc;
        k++;
      end
      step();
      p++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    if (k < n_words) chk("stream_timeout", 32'(k), 32'(n_words));
  endtask

  task automatic check_load(input string tag, input int wb, input int db,
                            input int n_exp, input int n_done);
    chk({tag, "_nwr"}, 32'(wr_addr.size() - wb), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (wb + i < wr_addr.size() && i < hs_cyc.size()) begin
        chk({tag, "_addr"}, 32'(wr_addr[wb + i]), 32'(i));
        chk({tag, "_data"}, wr_data[wb + i], exp_data[i]);
        chk({tag, "_wrcyc"}, 32'(wr_cyc[wb + i]), 32'(hs_cyc[i] + 1));
      end
    end
    chk({tag, "_ndone"}, 32'(done_cycs.size() - db), 32'(n_done));
    if (n_done == 1 && done_cycs.size() > db && hs_cyc.size() > 0)
      chk({tag, "_donecyc"}, 32'(done_cycs[db]), 32'(hs_cyc[hs_cyc.size() - 1] + 2));
  endtask

  task automatic run_basic(input string tag);
    int s, l, wb, db;
    wb = wr_addr.size();
    db = done_cycs.size();
    fifo_empty = 1'b1;
    do_start(s);
    chk({tag, "_busy_s1"}, 32'(busy), 32'd1);
    chk({tag, "_err_s1"}, 32'(err), 32'd0);
    stream(4, 3, 8'hFF, 1, 1'b0, l);
    repeat (6) step();
    check_load(tag, wb, db, 4, 1);
    if (done_cycs.size() > db) chk({tag, "_done_s7"}, 32'(done_cycs[db]), 32'(s + 7));
    chk({tag, "_busyfall"}, 32'(busy_fall), 32'(l + 3));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s, l, wb, db, bad;
    vals[0] = 16'h0001; vals[1] = 16'hFFFE; vals[2] = 16'h0003; vals[3] = 16'hFFFC;
    exp_data[0] = 32'h0000_0100; exp_data[1] = 32'hFFFF_FE00;
    exp_data[2] = 32'h0000_0300; exp_data[3] = 32'hFFFF_FC00;

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_empty = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_en",    32'(preload_en), 32'd0);
    chk("rst_pdone", 32'(preload_done), 32'd0);
    chk("rst_addr",  32'(preload_addr), 32'd0);
    chk("rst_data",  preload_data, 32'd0);

    run_basic("basic");

    // Backpressure: valid pattern 1,0,0,1,1,0,1 once the loader reaches LOAD
    wb = wr_addr.size(); db = done_cycs.size();
    do_start(s);
    step();
    stream(4, 3, 8'b0101_1001, 7, 1'b0, l);
    repeat (6) step();
    check_load("bp", wb, db, 4, 1);
    chk("bp_err", 32'(err), 32'd0);

    // FIFO still holds biases: loader must hold off for 10 cycles
    wb = wr_addr.size(); db = done_cycs.size();
    fifo_empty = 1'b0;
    do_start(s);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = vals[0]; s_last = 1'b0;
      if (s_ready !== 1'b0 || busy !== 1'b1 || preload_en !== 1'b0) bad++;
      step();
    end
    s_valid = 1'b0;
    chk("wait_bad", 32'(bad), 32'd0);
    chk("wait_nwr", 32'(wr_addr.size() - wb), 32'd0);
    fifo_empty = 1'b1;
    stream(4, 3, 8'hFF, 1, 1'b0, l);
    repeat (6) step();
    check_load("wait", wb, db, 4, 1);

    // Early last on beat 1: two writes, error, abort without commit
    wb = wr_addr.size(); db = done_cycs.size();
    do_start(s);
    stream(2, 1, 8'hFF, 1, 1'b0, l);
    chk("early_err",   32'(err), 32'd1);
    chk("early_busy",  32'(busy), 32'd0);
    chk("early_ready", 32'(s_ready), 32'd0);
    repeat (5) step();
    check_load("early", wb, db, 2, 0);
    chk("early_err_sticky", 32'(err), 32'd1);
    run_basic("after_early");

    // Missing last on final beat: error but still commits
    wb = wr_addr.size(); db = done_cycs.size();
    do_start(s);
    stream(4, 99, 8'hFF, 1, 1'b0, l);
    repeat (6) step();
    check_load("nolast", wb, db, 4, 1);
    chk("nolast_err", 32'(err), 32'd1);

    // Reset after two handshakes
    wb = wr_addr.size(); db = done_cycs.size();
    do_start(s);
    stream(2, 99, 8'hFF, 1, 1'b0, l);
    rst = 1'b1;
    step();
    chk("mrst_out", {24'd0, busy, done, err, s_ready, preload_en, preload_done, preload_addr}, 32'd0);
    chk("mrst_data", preload_data, 32'd0);
    rst = 1'b0;
    repeat (8) step();
    chk("mrst_nwr", 32'(wr_addr.size() - wb), 32'd2);
    chk("mrst_ndone", 32'(done_cycs.size() - db), 32'd0);
    run_basic("after_rst");

    // Start pulses during LOAD, COMMIT and the commit-pulse cycle are dropped
    wb = wr_addr.size(); db = done_cycs.size();
    do_start(s);
    stream(4, 3, 8'hFF, 1, 1'b1, l);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    repeat (6) step();
    check_load("sbusy", wb, db, 4, 1);
    chk("sbusy_busyfall", 32'(busy_fall), 32'(l + 3));
    chk("sbusy_idle", 32'(busy), 32'd0);

    chk("no_en_done_overlap", 32'(overlap), 32'd0);
    chk("done_eq_pdone", 32'(done_mis), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
